sequence_generator: RTL and testbench

Serial bit-pattern transmitter: the driving end of the single-wire serial bit stream that our sequence detectors consume. Accepts a pattern word, its bit length and a repeat count over a valid/ready handshake. Shifts the pattern out MSB-first, one bit per clock, with programmable idle gaps between repetitions. Used as the stimulus source and loopback partner for detector blocks on the same clock.

---
 rtl/sequence_generator.sv | 121 ++++++++++++
 tb/tb_sequence_generator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first on X,
// with a repeat count and programmable idle gaps between repetitions.
module sequence_generator #(
  parameter int   WIDTH    = 8,
  parameter int   GAP      = 2,
  parameter logic IDLE_LVL = 1'b0,
  parameter int   LEN_W    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic [3:0]       in_repeat,
  output logic             X,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] sh;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic [3:0]       rep;
  logic [GAP_W-1:0] gcnt;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;

  // Pattern is left-aligned so bit len-1 always sits at the MSB; shifting left
  // then walks the bits in descending order without a variable bit select.
  always_comb begin
    eff_len = in_len;
    if (in_len == '0 || in_len > LEN_W'(WIDTH)) eff_len = LEN_W'(WIDTH);
    aligned = in_data << (LEN_W'(WIDTH) - eff_len);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b1;
      X        <= IDLE_LVL;
      x_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pat      <= '0;
      sh       <= '0;
      len_r    <= '0;
      cnt      <= '0;
      rep      <= '0;
      gcnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (in_valid && in_ready) begin
            state    <= S_SHIFT;
            pat      <= aligned;
            sh       <= aligned << 1;
            len_r    <= eff_len;
            cnt      <= eff_len - 1'b1;
            rep      <= in_repeat;
            X        <= aligned[WIDTH-1];
            x_valid  <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            X   <= sh[WIDTH-1];
            sh  <= sh << 1;
          end else if (rep != '0) begin
            rep <= rep - 1'b1;
            if (GAP > 0) begin
              state   <= S_GAP;
              X       <= IDLE_LVL;
              x_valid <= 1'b0;
              gcnt    <= GAP_W'(GAP - 1);
            end else begin
              X   <= pat[WIDTH-1];
              sh  <= pat << 1;
              cnt <= len_r - 1'b1;
            end
          end else begin
            state    <= S_IDLE;
            X        <= IDLE_LVL;
            x_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            in_ready <= 1'b1;
          end
        end

        S_GAP: begin
          if (gcnt == '0) begin
            state   <= S_SHIFT;
            X       <= pat[WIDTH-1];
            sh      <= pat << 1;
            cnt     <= len_r - 1'b1;
            x_valid <= 1'b1;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: two instances (GAP=2/idle 0 and
// GAP=0/idle 1), a job-level reference model and a looped-back "111" detector.
module tb_sequence_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL [inst %0d] %s: got %0h expected %0h at cycle %0d", g, nm, act, exp_v, cyc);
    end
  endtask

  typedef struct packed {
    logic x;
    logic v;
    logic d;
  } item_t;

  for (genvar g = 0; g < 2; g++) begin : gb
    localparam int   G  = (g == 0) ? 2 : 0;
    localparam logic IL = (g == 0) ? 1'b0 : 1'b1;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_len;
    logic [3:0] in_repeat;
    logic       X;
    logic       x_valid;
    logic       busy;
    logic       done;

    item_t q[$];
    int    acc_mark = -10;
    bit    fin      = 1'b0;
    int    det_cnt  = 0;
    logic [2:0] d3;

    sequence_generator #(.WIDTH(8), .GAP(G), .IDLE_LVL(IL)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_len   (in_len),
      .in_repeat(in_repeat),
      .X        (X),
      .x_valid  (x_valid),
      .busy     (busy),
      .done     (done)
    );

    // Loopback partner: flags three consecutive valid 1 bits.
    always @(posedge clk or negedge rst) begin
      if (!rst) d3 <= 3'b000;
      else      d3 <= x_valid ? {d3[1:0], X} : 3'b000;
    end
    always @(negedge clk) if (d3 == 3'b111) det_cnt++;

    // Monitor: every busy/done cycle consumes one expected item.
    always @(negedge clk) begin : mon
      item_t e;
      if (rst) begin
        if (cyc == acc_mark + 1) chk(g, "first_bit_latency", {30'd0, busy, x_valid}, 32'd3);
        if (busy || done) begin
          if (q.size() == 0) chk(g, "unexpected_output", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            chk(g, "stream", {27'd0, X, x_valid, done, in_ready, busy},
                {27'd0, e.x, e.v, e.d, e.d, ~e.d});
          end
        end else begin
          chk(g, "idle_out", {29'd0, X, x_valid, in_ready}, {29'd0, IL, 1'b0, 1'b1});
        end
      end
    end

    task automatic model_push(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
      int n;
      logic [7:0] t;
      n = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
      for (int rr = 0; rr <= int'(r); rr++) begin
        for (int i = n - 1; i >= 0; i--) begin
          t = d >> i;
          q.push_back('{x: t[0], v: 1'b1, d: 1'b0});
        end
        if (rr < int'(r))
          for (int k = 0; k < G; k++) q.push_back('{x: IL, v: 1'b0, d: 1'b0});
      end
      q.push_back('{x: IL, v: 1'b0, d: 1'b1});
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r, input bit hold);
      int w;
      w = 0;
      in_valid  = 1'b1;
      in_data   = d;
      in_len    = l;
      in_repeat = r;
      while (!in_ready && w < 500) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        chk(g, "accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
      end else begin
        model_push(d, l, r);
        acc_mark = cyc;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
      end
    endtask

    task automatic drain();
      int w;
      w = 0;
      while ((q.size() != 0 || busy || done) && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) chk(g, "drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
      int s;
      bit h;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; in_repeat = '0;
      #12;
      chk(g, "reset_vals", {27'd0, X, x_valid, busy, done, in_ready}, {27'd0, IL, 4'b0001});
      @(negedge clk);
      rst = 1'b1;
      s = det_cnt;
      repeat (10) @(negedge clk);
      chk(g, "det_idle", det_cnt, s);

      send(8'b1011_0110, 4'd8, 4'd0, 1'b0); drain();
      send(8'h03, 4'd2, 4'd2, 1'b0); drain();
      send(8'h02, 4'd2, 4'd3, 1'b0); drain();
      send(8'($urandom), 4'd0, 4'd0, 1'b0); drain();
      send(8'($urandom), 4'd9, 4'd1, 1'b0); drain();
      send(8'h01, 4'd1, 4'd0, 1'b0); drain();

      s = det_cnt;
      send(8'b0000_0111, 4'd8, 4'd0, 1'b1);
      send(8'($urandom), 4'($urandom_range(1, 8)), 4'($urandom_range(0, 2)), 1'b0);
      drain();
      chk(g, "det_hit", {31'd0, det_cnt > s}, 32'd1);

      repeat (30) begin
        h = 1'($urandom_range(0, 1));
        send(8'($urandom), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 3)), h);
        if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_valid = 1'b0;
      drain();

      send(8'hA5, 4'd8, 4'd1, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1 chk(g, "async_reset", {27'd0, X, x_valid, busy, done, in_ready}, {27'd0, IL, 4'b0001});
      q.delete();
      acc_mark = -10;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      s = det_cnt;
      repeat (8) @(negedge clk);
      chk(g, "post_reset_quiet", det_cnt, s);
      fin = 1'b1;
    end
  end

  initial begin
    int w;
    w = 0;
    while (!(gb[0].fin && gb[1].fin) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20000) chk(-1, "global_timeout", 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
